// File: rtl/traffic_sequencer_pkg.sv
// Shared phase encodings and lamp patterns for the intersection sequencer.
package traffic_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_NS_G  = 3'd0,
        PH_NS_Y  = 3'd1,
        PH_RED_A = 3'd2,
        PH_EW_G  = 3'd3,
        PH_EW_Y  = 3'd4,
        PH_RED_B = 3'd5,
        PH_WALK  = 3'd6
    } phase_t;

    // Lamp bit order is {R,Y,G}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/traffic_sequencer_if.sv
// Tick/request inputs and lamp/debug outputs of the sequencer, bundled as one port.
interface traffic_sequencer_if;

    logic       en;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;
    logic       ped_pend;

    modport master (
        output en, ped_req,
        input  ns_light, ew_light, walk, phase, ped_pend
    );

    modport slave (
        input  en, ped_req,
        output ns_light, ew_light, walk, phase, ped_pend
    );

endinterface

// File: rtl/traffic_sequencer_phase_timer.sv
// Loadable tick counter; done flags the last en tick of the current phase.
module phase_timer #(
    parameter int counter_bits = 4
) (
    input  logic                    clk,
    input  logic                    r,
    input  logic                    en,
    input  logic                    load,
    input  logic [counter_bits-1:0] dur,
    output logic                    done
);

    logic [counter_bits-1:0] cnt;
    logic [counter_bits-1:0] last;

    assign last = dur - 1'b1;
    assign done = en && (cnt == last);

    always_ff @(posedge clk) begin
        if (r || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_sequencer.sv
// Intersection phase FSM with pedestrian latch and Moore lamp decode.
module traffic_sequencer
    import traffic_sequencer_pkg::*;
#(
    parameter int T_GREEN      = 12,
    parameter int T_YELLOW     = 3,
    parameter int T_ALLRED     = 1,
    parameter int T_WALK       = 6,
    parameter int counter_bits = 4
) (
    input  logic               clk,
    input  logic               r,
    traffic_sequencer_if.slave bus
);

    phase_t                  phase_q;
    phase_t                  phase_d;
    logic                    ped_pend_q;
    logic                    load;
    logic                    done;
    logic                    enter_walk;
    logic [counter_bits-1:0] dur;
    logic [2:0]              ns;
    logic [2:0]              ew;
    logic                    walk;

    phase_timer #(
        .counter_bits(counter_bits)
    ) u_timer (
        .clk  (clk),
        .r    (r),
        .en   (bus.en),
        .load (load),
        .dur  (dur),
        .done (done)
    );

    always_comb begin
        dur = counter_bits'(T_GREEN);
        case (phase_q)
            PH_NS_Y, PH_EW_Y:   dur = counter_bits'(T_YELLOW);
            PH_RED_A, PH_RED_B: dur = counter_bits'(T_ALLRED);
            PH_WALK:            dur = counter_bits'(T_WALK);
            default:            dur = counter_bits'(T_GREEN);
        endcase
    end

    // Illegal code 7 recovers through an all-red clearance with a fresh count
    always_comb begin
        phase_d = phase_q;
        load    = 1'b0;
        case (phase_q)
            PH_NS_G:  if (done) phase_d = PH_NS_Y;
            PH_NS_Y:  if (done) phase_d = PH_RED_A;
            PH_RED_A: if (done) phase_d = PH_EW_G;
            PH_EW_G:  if (done) phase_d = PH_EW_Y;
            PH_EW_Y:  if (done) phase_d = PH_RED_B;
            PH_RED_B: if (done) phase_d = ped_pend_q ? PH_WALK : PH_NS_G;
            PH_WALK:  if (done) phase_d = PH_NS_G;
            default: begin
                phase_d = PH_RED_A;
                load    = 1'b1;
            end
        endcase
    end

    assign enter_walk = (phase_q == PH_RED_B) && done && ped_pend_q;

    // A request arriving on the WALK entry edge is absorbed as served
    always_ff @(posedge clk) begin
        if (r) begin
            phase_q    <= PH_NS_G;
            ped_pend_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (enter_walk) begin
                ped_pend_q <= 1'b0;
            end else if (bus.ped_req) begin
                ped_pend_q <= 1'b1;
            end
        end
    end

    always_comb begin
        ns   = LAMP_R;
        ew   = LAMP_R;
        walk = 1'b0;
        case (phase_q)
            PH_NS_G: ns   = LAMP_G;
            PH_NS_Y: ns   = LAMP_Y;
            PH_EW_G: ew   = LAMP_G;
            PH_EW_Y: ew   = LAMP_Y;
            PH_WALK: walk = 1'b1;
            default: ;
        endcase
    end

    assign bus.ns_light = ns;
    assign bus.ew_light = ew;
    assign bus.walk     = walk;
    assign bus.phase    = phase_q;
    assign bus.ped_pend = ped_pend_q;

endmodule

// File: doc/traffic_sequencer.md
Name: traffic_sequencer

Overview:
- Phase sequencer for a two-way intersection with a pedestrian walk phase.
- Built around a loadable, tick-counting phase timer.
  - The timer measures the duration of each phase.
  - The FSM selects the next phase and reloads the timer when the current phase ends.
- Sits between the board-level tick divider (en pulse) and the light/LED drivers.

Parameters:
T_GREEN, 12, duration of each green phase in en ticks (>=1)
T_YELLOW, 3, duration of each yellow phase in en ticks (>=1)
T_ALLRED, 1, duration of each all-red clearance phase in en ticks (>=1)
T_WALK, 6, duration of the pedestrian walk phase in en ticks (>=1)
counter_bits, 4, timer width; must satisfy 2^counter_bits >= max(T_*)

Ports:
clk  input  1  system clock, all state updates on rising edge
r  input  1  reset; one clock, synchronous, active-high
en  input  1  tick enable; the timer advances only on cycles with en=1
ped_req  input  1  pedestrian request; a pulse or level, sampled every cycle
ns_light  output  3  north-south lamp {R,Y,G}, one-hot
ew_light  output  3  east-west lamp {R,Y,G}, one-hot
walk  output  1  walk lamp
phase  output  3  current phase code, for debug and 7-seg display
ped_pend  output  1  request latched and not yet served

Behaviour:
- Phase codes:
  - 0 NS_G, 1 NS_Y, 2 RED_A, 3 EW_G, 4 EW_Y, 5 RED_B, 6 WALK.
  - 7 is illegal.
- Phase sequence:
  - Fixed order 0→1→2→3→4→5.
  - From 5: go to 6 if ped_pend=1, else go to 0.
  - From 6: go to 0.
- Phase durations:
  - T_GREEN for 0 and 3.
  - T_YELLOW for 1 and 4.
  - T_ALLRED for 2 and 5.
  - T_WALK for 6.
- Timer:
  - cnt is cleared to 0 on phase entry.
  - On a cycle with en=1: if cnt == dur-1, the phase advances at that edge and cnt becomes 0; otherwise cnt becomes cnt+1.
  - On a cycle with en=0: cnt and phase hold.
  - A phase therefore lasts exactly dur en-pulses.
  - There is no modulo wrap beyond dur-1.
- Pedestrian latch:
  - ped_req=1 sets ped_pend; ped_pend stays set until it is served.
  - ped_pend is cleared at the edge that enters WALK.
  - ped_req=1 on that same cycle is absorbed and counts as served; ped_pend reads 0 after that edge.
  - ped_req asserted during WALK (after entry) sets ped_pend again. It is served on the next rotation and does not extend the current WALK.
- Outputs are a Moore decode of the phase register. They change in the same cycle the phase register updates, with no extra latency.
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - RED_A, RED_B: ns=100, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - WALK: ns=100, ew=100, walk=1.
  - walk=0 in every phase other than WALK.
- Reset:
  - r=1 at an edge forces phase=NS_G, cnt=0, ped_pend=0.
  - r has priority over en and ped_req.
  - r can be applied in any phase, mid-count included, with the same result.
  - Output values after reset: ns=001, ew=100, walk=0, phase=0, ped_pend=0.
- Illegal phase 7:
  - Outputs are all-red: ns=100, ew=100, walk=0.
  - The next edge goes to RED_A with cnt=0, regardless of en.
- Safety invariant: ns_light and ew_light are never both non-red.

Decomposition:
- Shared package contents:
  - phase encodings (PH_NS_G..PH_WALK).
  - lamp constants LAMP_R=100, LAMP_Y=010, LAMP_G=001.
- One sub-module: phase_timer, with ports clk, r, en, load, dur[counter_bits-1:0], and output done.
  - done=1 when en=1 and cnt==dur-1.
  - load=1 clears cnt.
- The FSM, the ped latch and the output decode stay in traffic_sequencer.

Test Plan:
1. Reset, then en=1 continuously, ped_req=0 → phase holds 0 for 12 cycles, 1 for 3, 2 for 1, 3 for 12, 4 for 3, 5 for 1, then returns to 0 at cycle 32. walk stays 0 throughout.
2. en pulses once every 4 clk → NS_G lasts exactly 48 clk. Phase and cnt are unchanged on cycles with en=0.
3. en=1; one-cycle ped_req pulse during EW_G → ped_pend=1 until RED_B ends. WALK lasts 6 cycles with walk=1 and both lamps 100, then NS_G follows. That full rotation is 38 cycles.
4. ped_req held high through entry into WALK and then released → ped_pend=0 after entry, and the next rotation skips WALK. A separate ped_req pulse at WALK cycle 3 → ped_pend=1 and WALK is served on the following rotation.
5. r pulsed at EW_Y cnt=1 with ped_pend=1 → next cycle phase=0, ns=001, ew=100, ped_pend=0. A full 12-tick NS_G follows.
6. Force phase=7 via testbench → next edge phase=2 with all-red outputs. The safety invariant is asserted every cycle across all scenarios.
